mem_arbiter_n: RTL

MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_picker.sv | 36 +++
 rtl/mem_arbiter_n.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the N-way memory arbiter.
//   arb_state_e  : arbiter state encoding (IDLE, GRANT, HOLD)
//   DEF_*        : default parameter values for mem_arbiter_n
package mem_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 2;
  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner search over an active-request vector.
//   active  : per-requester request flags
//   ptr     : search start index (round-robin pointer)
//   rr_mode : 1 = search upward from ptr modulo N, 0 = lowest index wins
//   winner  : selected index (0 when nothing is active)
//   valid   : at least one requester is active
module rr_picker #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     active,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_mode,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  int unsigned base;
  int unsigned cand;

  // First active index at or after base, wrapping modulo N.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    base   = rr_mode ? 32'(ptr) : 32'd0;
    cand   = 32'd0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (base + k) % N;
      if (!valid && active[IDX_W'(cand)]) begin
        valid  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-requester arbiter in front of a single-port memory.
//   clk, rst          : clock, synchronous active-high reset
//   req_read/_write   : per-requester command flags
//   req_addr/_wdata   : packed per-requester address / write data (slice i = requester i)
//   req_rdata         : read data broadcast, valid with req_resp
//   req_resp          : one-hot completion pulse to the owner
//   mem_*             : downstream memory command and response
//   grant_idx         : registered index of the current owner
//   busy              : a transaction is in GRANT or HOLD
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter bit          RR_EN   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_read,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic [DATA_W-1:0]            req_rdata,
  output logic [NUM_REQ-1:0]           req_resp,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_resp,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
  output logic                         busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e         state, state_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d, grant_idx_d, next_ptr;
  logic [NUM_REQ-1:0] active;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               own_read, own_write;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  // Unpack the flat request buses so the owner can be selected by index.
  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  assign active    = req_read | req_write;
  assign own_read  = req_read[grant_idx];
  assign own_write = req_write[grant_idx];
  assign busy      = (state != IDLE);
  assign next_ptr  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .active  (active),
    .ptr     (rr_ptr),
    .rr_mode (RR_EN),
    .winner  (pick_idx),
    .valid   (pick_valid)
  );

  // State, pointer and owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      grant_idx <= grant_idx_d;
    end
  end

  // Next state and downstream/upstream drive; all outputs forced low while rst
  // is high so a late mem_resp cannot complete an abandoned transaction.
  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    grant_idx_d = grant_idx;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    req_rdata   = '0;
    req_resp    = '0;

    if (rst) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_idx_d = pick_idx;
            state_d     = GRANT;
          end
        end
        GRANT: begin
          mem_addr = addr_arr[grant_idx];
          if (!own_read && !own_write) begin
            // Owner withdrew: abandon without touching the pointer.
            state_d = IDLE;
          end else begin
            mem_read  = own_read;
            mem_write = !own_read;
            if (!own_read) mem_wdata = wdata_arr[grant_idx];
            if (mem_resp) begin
              req_resp = NUM_REQ'(1'b1) << grant_idx;
              if (own_read) req_rdata = mem_rdata;
              rr_ptr_d = next_ptr;
              state_d  = HOLD;
            end
          end
        end
        HOLD: begin
          if (!mem_resp) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
